vga_photo_compositor: RTL and testbench
=======================================

Name: vga_photo_compositor

Overview:
- Display stage directly downstream of the SD/SDRAM photo buffer, running in the 25 MHz pixel domain.
- Generates 640x480@60 VGA timing and pops the full-screen background from SDRAM read channel 0 FIFO.
- Pops a 128x190 sprite tile from channel 1 FIFO and overlays it with a colour key.
- Issues a per-frame reload pulse that rewinds both SDRAM read pointers during vertical blanking.

Parameters:
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACT, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SPR_W, 128, sprite width
- SPR_H, 190, sprite height
- KEY_COLOR, 16'h0000, RGB565 transparent colour

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  asynchronous, active-high reset
- bg_rd_data  in  16  ch0 FIFO read data, valid 1 clk after bg_rd_en
- bg_empty  in  1  ch0 FIFO empty
- bg_rd_en  out  1  ch0 FIFO read request
- spr_rd_data  in  16  ch1 FIFO read data, valid 1 clk after spr_rd_en
- spr_rd_en  out  1  ch1 FIFO read request
- spr_en  in  1  sprite overlay enable
- spr_x  in  10  requested sprite left column
- spr_y  in  10  requested sprite top line
- frame_load  out  1  1-clk pulse; drives the SDRAM rd_load for ch0 and ch1
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_de  out  1  active-video flag
- vga_rgb  out  16  RGB565 pixel
- underflow  out  1  sticky: bg read attempted while empty

Behaviour:
- Reset is asynchronous, active-high. All outputs and counters are 0, except vga_hs = vga_vs = 1. Latched sprite state is cleared and spr_en_l = 0. Reset mid-frame restarts timing at (0,0).

Counters:
- h_cnt runs 0..H_TOTAL-1 (800). v_cnt runs 0..V_TOTAL-1 (525); it increments when h_cnt wraps and wraps itself to 0.
- active = (h_cnt < H_ACT) && (v_cnt < V_ACT).

Sprite latch (at h_cnt==0 && v_cnt==0):
- Registers spr_en_l.
- sx_l = min(spr_x, H_ACT-SPR_W); sy_l = min(spr_y, V_ACT-SPR_H). The window is therefore always fully on-screen, and the ch1 FIFO consumes exactly SPR_W*SPR_H words per frame.
- Mid-frame changes to spr_en/spr_x/spr_y have no effect until the next frame.

FIFO reads:
- bg_rd_en = active, combinational from the counters. Exactly 307200 reads per frame.
- in_win = spr_en_l && active && h_cnt in [sx_l, sx_l+SPR_W) && v_cnt in [sy_l, sy_l+SPR_H). spr_rd_en = in_win.
- Width rules: window compares use 11-bit sums, so no overflow occurs.

Pipeline (output latency 2 clk from the counter position):
- Stage 1 registers active, in_win, and hs/vs derived from the counters. Sync low when h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC); same form for v_cnt. It also registers empty_hit = bg_rd_en && bg_empty.
- Stage 2 registers vga_hs, vga_vs and vga_de from stage 1.
- vga_rgb source, in priority order:
  - 0 if !active_d1 or empty_hit_d1;
  - spr_rd_data if in_win_d1 && spr_rd_data != KEY_COLOR;
  - otherwise bg_rd_data.

frame_load:
- 1-clk pulse when h_cnt==0 && v_cnt==V_ACT+V_FP (vsync start). Never asserted in the same cycle as any rd_en.

underflow:
- Set on empty_hit_d1. Cleared only by rst or on the frame_load cycle; if set and clear coincide, clear wins.

Decomposition:
- Shared package vga_pkg holds the timing constants, H_TOTAL/V_TOTAL, and the RGB565 colour constants (BLACK, WHITE, etc.).
- Natural sub-module: vga_timing_gen (counters, hs/vs/active, frame_load). The compositor instantiates it and adds the sprite latch, read logic and pixel pipeline.

Test Plan:
- Reset held, then released → vga_hs=vga_vs=1, vga_de=0, bg_rd_en=0. After release: first bg_rd_en at clk 0, vga_de first high at clk 2.
- Run one frame with bg FIFO model never empty → 307200 bg_rd_en pulses, hs low 96 clk per 800, vs low 2 lines per 525. frame_load exactly once, at line 490 col 0. underflow stays 0.
- spr_en=1, spr_x=100, spr_y=50, sprite data 16'hF800 with every 4th word 16'h0000 → 24320 spr_rd_en per frame, only in cols 100..227 and lines 50..239. Output is red there, and bg data on keyed words.
- spr_x=600, spr_y=400 → clamped to 512/290. Window is cols 512..639, lines 290..479, 24320 reads.
- Force bg_empty=1 for 5 clk in active video → vga_rgb=0 on those 5 pixels 2 clk later, underflow=1, cleared at the next frame_load.
- Change spr_x mid-frame and assert rst at line 300 → window unchanged until next frame. rst immediately forces all outputs to reset values, and timing restarts at (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, colour constants and pipeline record for the VGA photo compositor.
package vga_pkg;

  localparam int H_ACT   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_ACT   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam int SPR_W = 128;
  localparam int SPR_H = 190;

  localparam logic [15:0] BLACK     = 16'h0000;
  localparam logic [15:0] WHITE     = 16'hFFFF;
  localparam logic [15:0] RED       = 16'hF800;
  localparam logic [15:0] GREEN     = 16'h07E0;
  localparam logic [15:0] BLUE      = 16'h001F;
  localparam logic [15:0] KEY_COLOR = BLACK;

  // Stage-1 record: everything sampled alongside the FIFO read request.
  typedef struct packed {
    logic active;
    logic in_win;
    logic hs;
    logic vs;
    logic empty_hit;
  } pipe_s;

  function automatic logic [9:0] clamp10(input logic [9:0] val, input logic [9:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/vga_photo_compositor_if.sv
// FIFO-side bundle: background (ch0) and sprite (ch1) read ports plus the per-frame pointer reload.
interface vga_photo_compositor_if;
  // Read semantics: rd_en is a pop request in the current cycle; rd_data is valid one clk later.
  // The compositor never backs off on empty for ch0; it flags it instead. frame_load rewinds both channels.
  logic [15:0] bg_rd_data;
  logic        bg_empty;
  logic        bg_rd_en;
  logic [15:0] spr_rd_data;
  logic        spr_rd_en;
  logic        frame_load;

  modport master (input bg_rd_data, bg_empty, spr_rd_data, output bg_rd_en, spr_rd_en, frame_load);
  modport slave  (output bg_rd_data, bg_empty, spr_rd_data, input bg_rd_en, spr_rd_en, frame_load);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters with combinational sync, active-video and per-frame reload strobe.
module vga_timing_gen #(
  parameter int H_ACT  = vga_pkg::H_ACT,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_ACT  = vga_pkg::V_ACT,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       active,
  output logic       hs,
  output logic       vs,
  output logic       frame_load
);
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == 10'(H_TOT - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == 10'(V_TOT - 1)) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    active     = (h_cnt < 10'(H_ACT)) && (v_cnt < 10'(V_ACT));
    hs         = !((h_cnt >= 10'(H_ACT + H_FP)) && (h_cnt < 10'(H_ACT + H_FP + H_SYNC)));
    vs         = !((v_cnt >= 10'(V_ACT + V_FP)) && (v_cnt < 10'(V_ACT + V_FP + V_SYNC)));
    // Vsync start lies in vertical blanking, so this never coincides with a read.
    frame_load = (h_cnt == '0) && (v_cnt == 10'(V_ACT + V_FP));
  end

endmodule

// File: rtl/vga_photo_compositor.sv
// Pixel-domain compositor: background stream with a colour-keyed sprite tile, 2-clk output pipeline.
module vga_photo_compositor #(
  parameter int          H_ACT     = vga_pkg::H_ACT,
  parameter int          H_FP      = vga_pkg::H_FP,
  parameter int          H_SYNC    = vga_pkg::H_SYNC,
  parameter int          H_BP      = vga_pkg::H_BP,
  parameter int          V_ACT     = vga_pkg::V_ACT,
  parameter int          V_FP      = vga_pkg::V_FP,
  parameter int          V_SYNC    = vga_pkg::V_SYNC,
  parameter int          V_BP      = vga_pkg::V_BP,
  parameter int          SPR_W     = vga_pkg::SPR_W,
  parameter int          SPR_H     = vga_pkg::SPR_H,
  parameter logic [15:0] KEY_COLOR = vga_pkg::KEY_COLOR
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_photo_compositor_if.master fifo,
  input  logic                   spr_en,
  input  logic [9:0]             spr_x,
  input  logic [9:0]             spr_y,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_de,
  output logic [15:0]            vga_rgb,
  output logic                   underflow
);
  import vga_pkg::*;

  localparam logic [9:0] SX_MAX = 10'(H_ACT - SPR_W);
  localparam logic [9:0] SY_MAX = 10'(V_ACT - SPR_H);

  logic [9:0]  h_cnt, v_cnt;
  logic        active, hs, vs, frame_load;
  logic        frame_start, spr_en_l, en_eff, rd_ok, in_win;
  logic [9:0]  sx_l, sy_l, sx_eff, sy_eff;
  pipe_s       d1;
  logic [15:0] rgb_next;

  vga_timing_gen #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active     (active),
    .hs         (hs),
    .vs         (vs),
    .frame_load (frame_load)
  );

  // At (0,0) the freshly clamped inputs are used directly, so the first pixel of a frame
  // already sees the new window and every frame pops exactly SPR_W*SPR_H sprite words.
  always_comb begin
    frame_start = (h_cnt == '0) && (v_cnt == '0);
    en_eff      = frame_start ? spr_en : spr_en_l;
    sx_eff      = frame_start ? clamp10(spr_x, SX_MAX) : sx_l;
    sy_eff      = frame_start ? clamp10(spr_y, SY_MAX) : sy_l;
    // Counters sit at (0,0) while reset is held; keep the FIFOs untouched until release.
    rd_ok       = active && !rst;
    in_win      = en_eff && rd_ok
               && ({1'b0, h_cnt} >= {1'b0, sx_eff}) && ({1'b0, h_cnt} < {1'b0, sx_eff} + 11'(SPR_W))
               && ({1'b0, v_cnt} >= {1'b0, sy_eff}) && ({1'b0, v_cnt} < {1'b0, sy_eff} + 11'(SPR_H));
  end

  assign fifo.bg_rd_en   = rd_ok;
  assign fifo.spr_rd_en  = in_win;
  assign fifo.frame_load = frame_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spr_en_l <= 1'b0;
      sx_l     <= '0;
      sy_l     <= '0;
    end else if (frame_start) begin
      spr_en_l <= en_eff;
      sx_l     <= sx_eff;
      sy_l     <= sy_eff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '{active: 1'b0, in_win: 1'b0, hs: 1'b1, vs: 1'b1, empty_hit: 1'b0};
    end else begin
      d1 <= '{active: active, in_win: in_win, hs: hs, vs: vs, empty_hit: rd_ok && fifo.bg_empty};
    end
  end

  always_comb begin
    rgb_next = BLACK;
    if (!d1.active || d1.empty_hit) begin
      rgb_next = BLACK;
    end else if (d1.in_win && (fifo.spr_rd_data != KEY_COLOR)) begin
      rgb_next = fifo.spr_rd_data;
    end else begin
      rgb_next = fifo.bg_rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_hs    <= 1'b1;
      vga_vs    <= 1'b1;
      vga_de    <= 1'b0;
      vga_rgb   <= '0;
      underflow <= 1'b0;
    end else begin
      vga_hs  <= d1.hs;
      vga_vs  <= d1.vs;
      vga_de  <= d1.active;
      vga_rgb <= rgb_next;
      // The reload at vsync start re-arms the flag for the next frame.
      if (frame_load) underflow <= 1'b0;
      else if (d1.empty_hit) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_photo_compositor.sv
// Directed bench for the compositor on a shrunken raster (56x37 total, 40x30 active, 8x6 sprite).
module tb_vga_photo_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic        spr_en;
  logic [9:0]  spr_x, spr_y;
  logic        vga_hs, vga_vs, vga_de, underflow;
  logic [15:0] vga_rgb;

  int passes = 0;
  int total  = 0;

  // Reference raster position, advanced by the same clock/reset the DUT sees.
  int mh, mv;
  // FIFO models: word index restarts on every pointer reload.
  int bg_i, spr_i;

  typedef struct packed {
    logic [15:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        emp;
  } exp_t;

  vga_photo_compositor_if ifc ();

  vga_photo_compositor #(
    .H_ACT(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACT(30), .V_FP(3), .V_SYNC(2), .V_BP(2),
    .SPR_W(8),  .SPR_H(6), .KEY_COLOR(16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo      (ifc.master),
    .spr_en    (spr_en),
    .spr_x     (spr_x),
    .spr_y     (spr_y),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs),
    .vga_de    (vga_de),
    .vga_rgb   (vga_rgb),
    .underflow (underflow)
  );

  always #20 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mh <= 0;
      mv <= 0;
    end else if (mh == 55) begin
      mh <= 0;
      mv <= (mv == 36) ? 0 : mv + 1;
    end else begin
      mh <= mh + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bg_i             <= 0;
      spr_i            <= 0;
      ifc.bg_rd_data   <= 16'h0;
      ifc.spr_rd_data  <= 16'h0;
    end else if (ifc.frame_load) begin
      bg_i  <= 0;
      spr_i <= 0;
    end else begin
      if (ifc.bg_rd_en && !ifc.bg_empty) begin
        ifc.bg_rd_data <= 16'h4000 | 16'(bg_i);
        bg_i           <= bg_i + 1;
      end
      if (ifc.spr_rd_en) begin
        ifc.spr_rd_data <= (spr_i % 4 == 3) ? 16'h0000 : 16'hF800;
        spr_i           <= spr_i + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks one full frame from (0,0), predicting every output; the video outputs lag the raster by 2.
  task automatic scan_frame(input string tag, input bit ex_en, input int ex_sx, input int ex_sy,
                            input int e_v, input int e_h, input int chg_v, input int chg_x);
    int n = 0;
    int bg_idx = 0, spr_idx = 0;
    int rgb_mis = 0, de_mis = 0, hs_mis = 0, vs_mis = 0, bgrd_mis = 0, sprrd_mis = 0;
    int bg_cnt = 0, spr_cnt = 0, hs_lo = 0, vs_lo = 0, de_cnt = 0;
    int fl_cnt = 0, fl_h = -1, fl_v = -1, fl_ovl = 0, uf_hi = 0, emp_zero = 0;
    logic uf_set = 1'b0, uf_clr = 1'b1;
    logic [15:0] bg_word = 16'h0, spr_word = 16'h0;
    bit act, win, emp;
    exp_t e1, e2, cur;
    while (!(mh == 0 && mv == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " align"}, 32'(n < 3000), 32'd1);
    e1 = '{rgb: 16'h0, de: 1'b0, hs: 1'b1, vs: 1'b1, emp: 1'b0};
    e2 = e1;
    for (int i = 0; i < 2072; i++) begin
      emp = (mv == e_v) && (mh >= e_h) && (mh < e_h + 5);
      ifc.bg_empty = emp;
      if (mh == 0 && mv == chg_v) spr_x = 10'(chg_x);
      #1;
      act = (mh < 40) && (mv < 30);
      win = ex_en && act && (mh >= ex_sx) && (mh < ex_sx + 8) && (mv >= ex_sy) && (mv < ex_sy + 6);
      cur.de  = act;
      cur.hs  = !((mh >= 44) && (mh < 50));
      cur.vs  = !((mv >= 33) && (mv < 35));
      cur.emp = act && emp;
      cur.rgb = 16'h0;
      if (win) begin
        spr_word = (spr_idx % 4 == 3) ? 16'h0000 : 16'hF800;
        spr_idx++;
      end
      if (act && !emp) begin
        bg_word = 16'h4000 | 16'(bg_idx);
        bg_idx++;
        cur.rgb = (win && spr_word != 16'h0000) ? spr_word : bg_word;
      end
      if (vga_rgb !== e2.rgb) rgb_mis++;
      if (vga_de  !== e2.de)  de_mis++;
      if (vga_hs  !== e2.hs)  hs_mis++;
      if (vga_vs  !== e2.vs)  vs_mis++;
      if (e2.emp && vga_rgb === 16'h0) emp_zero++;
      if (ifc.bg_rd_en  !== act) bgrd_mis++;
      if (ifc.spr_rd_en !== win) sprrd_mis++;
      if (ifc.bg_rd_en)  bg_cnt++;
      if (ifc.spr_rd_en) spr_cnt++;
      if (!vga_hs) hs_lo++;
      if (!vga_vs) vs_lo++;
      if (vga_de)  de_cnt++;
      if (underflow) uf_hi++;
      if (ifc.frame_load) begin
        fl_cnt++;
        fl_h = mh;
        fl_v = mv;
        if (ifc.bg_rd_en || ifc.spr_rd_en) fl_ovl++;
      end
      if (mh == 0 && mv == e_v + 1) uf_set = underflow;
      if (mh == 2 && mv == 33) uf_clr = underflow;
      e2 = e1;
      e1 = cur;
      @(negedge clk);
    end
    ifc.bg_empty = 1'b0;
    check({tag, " rgb_mismatches"}, 32'(rgb_mis), 32'd0);
    check({tag, " de_mismatches"}, 32'(de_mis), 32'd0);
    check({tag, " hs_mismatches"}, 32'(hs_mis), 32'd0);
    check({tag, " vs_mismatches"}, 32'(vs_mis), 32'd0);
    check({tag, " bg_rd_en_mismatches"}, 32'(bgrd_mis), 32'd0);
    check({tag, " spr_rd_en_mismatches"}, 32'(sprrd_mis), 32'd0);
    check({tag, " bg_reads"}, 32'(bg_cnt), 32'd1200);
    check({tag, " spr_reads"}, 32'(spr_cnt), ex_en ? 32'd48 : 32'd0);
    check({tag, " hs_low_cycles"}, 32'(hs_lo), 32'd222);
    check({tag, " vs_low_cycles"}, 32'(vs_lo), 32'd112);
    check({tag, " de_cycles"}, 32'(de_cnt), 32'd1200);
    check({tag, " frame_load_count"}, 32'(fl_cnt), 32'd1);
    check({tag, " frame_load_col"}, 32'(fl_h), 32'd0);
    check({tag, " frame_load_line"}, 32'(fl_v), 32'd33);
    check({tag, " frame_load_read_overlap"}, 32'(fl_ovl), 32'd0);
    if (e_v >= 0) begin
      check({tag, " empty_pixels_black"}, 32'(emp_zero), 32'd5);
      check({tag, " underflow_set"}, 32'(uf_set), 32'd1);
      check({tag, " underflow_cleared"}, 32'(uf_clr), 32'd0);
    end else begin
      check({tag, " underflow_idle"}, 32'(uf_hi), 32'd0);
    end
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    spr_en       = 1'b0;
    spr_x        = 10'd0;
    spr_y        = 10'd0;
    ifc.bg_empty = 1'b0;

    // Reset held
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst vga_hs", 32'(vga_hs), 32'd1);
    check("rst vga_vs", 32'(vga_vs), 32'd1);
    check("rst vga_de", 32'(vga_de), 32'd0);
    check("rst vga_rgb", 32'(vga_rgb), 32'd0);
    check("rst bg_rd_en", 32'(ifc.bg_rd_en), 32'd0);
    check("rst spr_rd_en", 32'(ifc.spr_rd_en), 32'd0);
    check("rst frame_load", 32'(ifc.frame_load), 32'd0);
    check("rst underflow", 32'(underflow), 32'd0);

    // Release: first read immediately at (0,0), vga_de two clocks later
    rst = 1'b0;
    #1;
    check("release bg_rd_en clk0", 32'(ifc.bg_rd_en), 32'd1);
    check("release vga_de clk0", 32'(vga_de), 32'd0);
    @(negedge clk);
    check("release vga_de clk1", 32'(vga_de), 32'd0);
    @(negedge clk);
    check("release vga_de clk2", 32'(vga_de), 32'd1);

    // Background only
    scan_frame("f1_bg_only", 1'b0, 0, 0, -1, 0, -1, 0);

    // Sprite at (10,5): window cols 10..17, lines 5..10
    spr_en = 1'b1;
    spr_x  = 10'd10;
    spr_y  = 10'd5;
    scan_frame("f2_sprite", 1'b1, 10, 5, -1, 0, -1, 0);

    // Sprite requested at (38,28): clamped to (32,24)
    spr_x = 10'd38;
    spr_y = 10'd28;
    scan_frame("f3_clamp", 1'b1, 32, 24, -1, 0, -1, 0);

    // Background empty for 5 pixels on line 3, cols 12..16
    spr_en = 1'b0;
    scan_frame("f4_underflow", 1'b0, 0, 0, 3, 12, -1, 0);

    // Mid-frame spr_x change on line 8 must not move this frame's window
    spr_en = 1'b1;
    spr_x  = 10'd10;
    spr_y  = 10'd5;
    scan_frame("f5_midframe", 1'b1, 10, 5, -1, 0, 8, 20);

    // Reset in the middle of the next frame (line 20)
    n = 0;
    while (mv != 20 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("midrst align", 32'(n < 3000), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst vga_hs", 32'(vga_hs), 32'd1);
    check("midrst vga_vs", 32'(vga_vs), 32'd1);
    check("midrst vga_de", 32'(vga_de), 32'd0);
    check("midrst vga_rgb", 32'(vga_rgb), 32'd0);
    check("midrst bg_rd_en", 32'(ifc.bg_rd_en), 32'd0);
    check("midrst spr_rd_en", 32'(ifc.spr_rd_en), 32'd0);
    check("midrst underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst restart bg_rd_en", 32'(ifc.bg_rd_en), 32'd1);

    // Timing restarts at (0,0) and latches the spr_x written in the previous frame
    scan_frame("f7_after_rst", 1'b1, 20, 5, -1, 0, -1, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
